mem_block_arbiter: RTL and testbench

Sequencer and two-port round-robin arbiter in front of the shared 512-word x 32-bit block memory, which has a 16-word (512-bit) block port, a synchronous write and a combinational read. Two requesters (e.g. a loader and the compute datapath) issue block read/write transactions with a req/ack handshake. The block serialises them, drives the memory port from registers, captures read data and rejects out-of-range bases.

---
 rtl/mem_block_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_rr.sv | 25 ++
 rtl/mem_block_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_block_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_block_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Purpose  : Shared sizing constants and FSM state encoding for the block
//            memory sequencer/arbiter and its round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int ADDR_W      = 9;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int BLOCK_W     = WORD_W * BLOCK_WORDS;

  // Highest base whose whole block still fits inside the memory.
  localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'((2 ** ADDR_W) - BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_rr
// Purpose  : Combinational two-way round-robin pick.
// Ports    : req0, req1   - pending requests
//            last_grant   - port that won the most recent tie
//            grant        - index of the winning port
//            valid        - at least one request is pending
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  assign valid = req0 | req1;
  // On a tie the port that did not win last time goes first; otherwise the
  // sole requester wins (req1 alone -> 1, req0 alone -> 0).
  assign grant = (req0 & req1) ? ~last_grant : req1;

endmodule
`default_nettype wire

// File: rtl/mem_block_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_arbiter
// Purpose  : Serialises block read/write transactions from two requesters
//            onto a shared 512 x 32 block memory (16-word block port).
// Ports    : clk, rst_n                 - clock, synchronous active-low reset
//            reqN/weN/addrN/wdataN       - request side per port (N = 0,1)
//            ackN/errN/rdataN            - completion side per port
//            mem_addr/mem_wdata/mem_we   - registered memory port drive
//            mem_rdata                   - combinational memory read block
// Revision : 1.0 - initial release
// ============================================================================
module mem_block_arbiter
  import mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [BLOCK_W-1:0]  wdata0,
  input  logic [BLOCK_W-1:0]  wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic                err0,
  output logic                err1,
  output logic [BLOCK_W-1:0]  rdata0,
  output logic [BLOCK_W-1:0]  rdata1,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BLOCK_W-1:0]  mem_wdata,
  output logic                mem_we,
  input  logic [BLOCK_W-1:0]  mem_rdata
);

  state_t state;
  logic   last_grant;
  logic   cur_port;
  logic   cur_we;
  logic   err_q;

  logic                sel_grant;
  logic                sel_valid;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BLOCK_W-1:0]  sel_wdata;
  logic                sel_bad;

  mem_arb_rr u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant      (sel_grant),
    .valid      (sel_valid)
  );

  assign sel_we    = sel_grant ? we1    : we0;
  assign sel_addr  = sel_grant ? addr1  : addr0;
  assign sel_wdata = sel_grant ? wdata1 : wdata0;
  assign sel_bad   = (sel_addr > MAX_BASE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      cur_we     <= 1'b0;
      err_q      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            cur_port  <= sel_grant;
            cur_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            err_q     <= sel_bad;
            // Only contested grants move the round-robin pointer.
            if (req0 && req1) last_grant <= sel_grant;
            if (sel_bad) begin
              // Out-of-range base: answer immediately, never touch memory.
              ack0  <= ~sel_grant;
              ack1  <= sel_grant;
              err0  <= ~sel_grant;
              err1  <= sel_grant;
              state <= DONE;
            end else begin
              mem_we <= sel_we;
              state  <= ACCESS;
            end
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (!cur_we) begin
            if (cur_port) rdata1 <= mem_rdata;
            else          rdata0 <= mem_rdata;
          end
          ack0  <= ~cur_port;
          ack1  <= cur_port;
          err0  <= err_q & ~cur_port;
          err1  <= err_q & cur_port;
          state <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_block_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_block_arbiter
// Purpose  : Self-checking bench for mem_block_arbiter with a behavioural
//            512 x 32 block memory and a shadow copy of expected contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_block_arbiter;
  import mem_arb_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req0, req1, we0, we1;
  logic [ADDR_W-1:0]   addr0, addr1;
  logic [BLOCK_W-1:0]  wdata0, wdata1;
  logic                ack0, ack1, err0, err1;
  logic [BLOCK_W-1:0]  rdata0, rdata1;
  logic [ADDR_W-1:0]   mem_addr;
  logic [BLOCK_W-1:0]  mem_wdata;
  logic                mem_we;
  logic [BLOCK_W-1:0]  mem_rdata;

  always #5 clk = ~clk;

  mem_block_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Behavioural memory: synchronous write, combinational block read.
  // A write coinciding with a reset edge is not performed.
  logic [31:0] mem [512];
  bit          mem_init_req;
  int          we_cycles = 0;
  int          ack_total = 0;

  always @(posedge clk) begin
    if (mem_init_req) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (mem_we && rst_n) begin
      for (int k = 0; k < BLOCK_WORDS; k++)
        mem[(int'(mem_addr) + k) % 512] <= mem_wdata[32*k +: 32];
    end
    if (mem_we) we_cycles <= we_cycles + 1;
    if (ack0 || ack1) ack_total <= ack_total + 1;
  end

  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < BLOCK_WORDS; k++)
      mem_rdata[32*k +: 32] = mem[(int'(mem_addr) + k) % 512];
  end

  logic [31:0] exp_mem [512];
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit               port;
    bit               we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]      seed;
    bit               exp_err;
    logic [31:0]      exp_w0;
    logic [31:0]      exp_w8;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [BLOCK_W-1:0] blk(input logic [31:0] seed);
    logic [BLOCK_W-1:0] b;
    for (int k = 0; k < BLOCK_WORDS; k++) b[32*k +: 32] = seed + 32'(k);
    return b;
  endfunction

  function automatic logic [BLOCK_W-1:0] exp_blk(input logic [ADDR_W-1:0] a);
    logic [BLOCK_W-1:0] b;
    for (int k = 0; k < BLOCK_WORDS; k++) b[32*k +: 32] = exp_mem[(int'(a) + k) % 512];
    return b;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string name, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic chk_reset_outputs;
    chk_i("rst_ack0", int'(ack0), 0);
    chk_i("rst_ack1", int'(ack1), 0);
    chk_i("rst_err", int'(err0 | err1), 0);
    chk_i("rst_mem_we", int'(mem_we), 0);
    chk_i("rst_mem_addr", int'(mem_addr), 0);
    chk_b("rst_mem_wdata", mem_wdata, '0);
    chk_b("rst_rdata0", rdata0, '0);
    chk_b("rst_rdata1", rdata1, '0);
  endtask

  task automatic drive(input bit port, input bit r, input bit w,
                       input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
    if (port) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else      begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  // One single-port transaction, started from IDLE.
  task automatic do_txn(input vec_t v);
    logic [BLOCK_W-1:0] r0s, r1s, exp_rd, got_rd, oth_rd, oth_exp;
    int  wb, lat;
    bit  got_ack;
    r0s = rdata0;
    r1s = rdata1;
    wb  = we_cycles;
    drive(v.port, 1'b1, v.we, v.addr, blk(v.seed));
    step;
    lat = 1;
    got_ack = v.port ? ack1 : ack0;
    while (!got_ack && lat < 6) begin
      step;
      lat++;
      got_ack = v.port ? ack1 : ack0;
    end
    chk_i("txn_ack_seen", int'(got_ack), 1);
    chk_i("txn_latency", lat, v.exp_err ? 1 : 2);
    chk_i("txn_err", int'(v.port ? err1 : err0), int'(v.exp_err));
    chk_i("txn_other_ack", int'(v.port ? ack0 : ack1), 0);
    exp_rd  = (!v.exp_err && !v.we) ? exp_blk(v.addr) : (v.port ? r1s : r0s);
    got_rd  = v.port ? rdata1 : rdata0;
    oth_rd  = v.port ? rdata0 : rdata1;
    oth_exp = v.port ? r0s : r1s;
    chk_b("txn_rdata", got_rd, exp_rd);
    chk_b("txn_other_rdata", oth_rd, oth_exp);
    if (!v.exp_err && !v.we) begin
      chk_i("txn_word0", int'(got_rd[31:0]), int'(v.exp_w0));
      chk_i("txn_word8", int'(got_rd[32*8 +: 32]), int'(v.exp_w8));
    end
    if (v.we && !v.exp_err)
      for (int k = 0; k < BLOCK_WORDS; k++) exp_mem[(int'(v.addr) + k) % 512] = v.seed + 32'(k);
    drive(v.port, 1'b0, 1'b0, '0, '0);
    step;
    chk_i("txn_ack_pulse", int'(ack0 | ack1), 0);
    chk_i("txn_we_cycles", we_cycles - wb, (v.we && !v.exp_err) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   ab, c, n_ack, first_port;
    int   ack_cyc [4];
    int   ack_prt [4];
    bit   seen;

    for (int i = 0; i < 512; i++) exp_mem[i] = 32'hA000_0000 | 32'(i);
    vecs[0] = '{1'b0, 1'b1, 9'h000, 32'h1000, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 9'h000, 32'h0,    1'b0, 32'h1000, 32'h1008};
    vecs[2] = '{1'b0, 1'b1, 9'h100, 32'h2000, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 9'h108, 32'h0,    1'b0, 32'h2008, 32'hA000_0110};
    vecs[4] = '{1'b1, 1'b0, 9'd497, 32'h0,    1'b1, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 9'd496, 32'h0,    1'b0, 32'hA000_01F0, 32'hA000_01F8};
    vecs[6] = '{1'b0, 1'b1, 9'd504, 32'h7000, 1'b1, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 9'h108, 32'h0,    1'b0, 32'h2008, 32'hA000_0110};

    rst_n = 1'b0; mem_init_req = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step; step;
    mem_init_req = 1'b0;
    step;
    chk_reset_outputs();
    rst_n = 1'b1;
    step;

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Both ports requesting continuously: grants must alternate 0,1,0,1.
    drive(1'b0, 1'b1, 1'b0, 9'h010, '0);
    drive(1'b1, 1'b1, 1'b0, 9'h020, '0);
    step;
    n_ack = 0;
    for (c = 0; c < 12; c++) begin
      if (c > 0) step;
      if (ack0 || ack1) begin
        if (n_ack < 4) begin
          ack_cyc[n_ack] = c;
          ack_prt[n_ack] = ack1 ? 1 : 0;
        end
        if (ack0) chk_b("tie_rdata0", rdata0, exp_blk(9'h010));
        if (ack1) chk_b("tie_rdata1", rdata1, exp_blk(9'h020));
        n_ack++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    step; step;
    chk_i("tie_ack_count", n_ack, 4);
    if (n_ack >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk_i("tie_order", ack_prt[i], i % 2);
        chk_i("tie_cycle", ack_cyc[i], 1 + 3 * i);
      end
    end

    // Reset caught during the ACCESS cycle of a write.
    ab = ack_total;
    drive(1'b0, 1'b1, 1'b1, 9'h040, blk(32'h5000));
    step;
    chk_i("rst_mid_mem_we", int'(mem_we), 1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step; step;
    chk_reset_outputs();
    rst_n = 1'b1;
    step; step;
    chk_i("rst_mid_no_ack", ack_total - ab, 0);
    do_txn('{1'b0, 1'b0, 9'h040, 32'h0, 1'b0, 32'hA000_0040, 32'hA000_0048});

    // First tie after reset goes to port 0.
    drive(1'b0, 1'b1, 1'b0, 9'h010, '0);
    drive(1'b1, 1'b1, 1'b0, 9'h020, '0);
    step;
    seen = 0; first_port = -1;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (ack0 || ack1) begin seen = 1; first_port = ack1 ? 1 : 0; end
      else step;
    end
    chk_i("post_rst_tie_first", first_port, 0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    step;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (ack1) seen = 1;
      else step;
    end
    chk_i("post_rst_tie_second", int'(seen), 1);
    chk_b("post_rst_rdata1", rdata1, exp_blk(9'h020));
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    step; step;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
